cpu_mem_bridge: RTL

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/gm64_pkg.sv | 32 +++
 rtl/bridge_timeout.sv | 32 +++
 rtl/cpu_mem_bridge.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/gm64_pkg.sv
// gm64_pkg -- definitions shared by the CPU-to-PSRAM bridge.
//   bridge_state_e : bridge FSM state encoding. The TEST_* states exist only
//                    when GM64_MEMTEST_EN is defined.
//   TEST_PATTERN   : byte written and read back by the power-on self-test.
//   TEST_LEN       : number of consecutive offsets the self-test covers.
//   mem_addr()     : maps a 16-bit CPU address to a 24-bit PSRAM address.
package gm64_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3
`ifdef GM64_MEMTEST_EN
      ,
      ST_TEST_WR   = 3'd4,
      ST_TEST_RD   = 3'd5,
      ST_TEST_CHK  = 3'd6
`endif
   } bridge_state_e;

   localparam logic [7:0] TEST_PATTERN = 8'hAA;
   localparam int         TEST_LEN     = 4;

   // The 24-bit sum wraps modulo 2^24, so a large base cannot overflow into
   // a wider address.
   function automatic logic [23:0] mem_addr(input logic [23:0] base,
                                            input logic [15:0] cpu_addr);
      return base + {8'h00, cpu_addr};
   endfunction

endpackage

// File: rtl/bridge_timeout.sv
// bridge_timeout -- cycle counter used to bound one memory access.
//   clkSys  : clock, rising edge
//   rst     : asynchronous reset, active low
//   clr     : synchronous clear; has priority over en
//   en      : count this cycle
//   expired : high during the TIMEOUT-th consecutive enabled cycle
module bridge_timeout #(
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic clkSys,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt;

   // The compare is done 17 bits wide so that TIMEOUT = 0 or 1 expires on
   // the first enabled cycle instead of wrapping.
   assign expired = en && (({1'b0, cnt} + 17'd1) >= {1'b0, TIMEOUT});

   always_ff @(posedge clkSys or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 16'd1;
   end

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge -- turns one-cycle CPU bus strobes into PSRAM controller
// transactions and stalls the CPU until each transaction completes.
//   clkSys, rst                   : clock (rising edge), async active-low reset
//   i_cpuStrobe/Addr/WE/Data      : CPU bus cycle request
//   o_cpuData, o_rdy              : read data returned to the CPU, CPU ready
//   o_cs (active low), o_write,
//   o_address, o_dataToWrite      : one-cycle request to the memory controller
//   i_dataRead, i_busy,
//   i_dataReady                   : memory controller response
//   o_error                       : sticky, set when an access times out
//   o_testDone, o_testFail        : power-on self-test status
// Build option: define GM64_MEMTEST_EN to compile in the power-on self-test.
// Without it, o_testDone is tied to 1 and o_testFail to 0.
module cpu_mem_bridge
   import gm64_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR = 24'h000000,
   parameter logic [15:0] TIMEOUT   = 16'd1024
) (
   input  logic        clkSys,
   input  logic        rst,
   input  logic        i_cpuStrobe,
   input  logic [15:0] i_cpuAddr,
   input  logic        i_cpuWE,
   input  logic [7:0]  i_cpuData,
   output logic [7:0]  o_cpuData,
   output logic        o_rdy,
   output logic        o_cs,
   output logic        o_write,
   output logic [23:0] o_address,
   output logic [7:0]  o_dataToWrite,
   input  logic [7:0]  i_dataRead,
   input  logic        i_busy,
   input  logic        i_dataReady,
   output logic        o_error,
   output logic        o_testDone,
   output logic        o_testFail
);

   localparam logic [2:0] IDLE      = ST_IDLE;
   localparam logic [2:0] ISSUE     = ST_ISSUE;
   localparam logic [2:0] WAIT_BUSY = ST_WAIT_BUSY;
   localparam logic [2:0] WAIT_DONE = ST_WAIT_DONE;
`ifdef GM64_MEMTEST_EN
   localparam logic [2:0] TEST_WR   = ST_TEST_WR;
   localparam logic [2:0] TEST_RD   = ST_TEST_RD;
   localparam logic [2:0] TEST_CHK  = ST_TEST_CHK;
   localparam logic [2:0] RST_STATE = TEST_WR;
   localparam int         OFF_W     = $clog2(TEST_LEN);
`else
   localparam logic [2:0] RST_STATE = IDLE;
`endif

   logic [2:0]  state;
   logic [15:0] addr_q;
   logic        we_q;
   logic [7:0]  wd_q;

   logic        tmo_active;
   logic        expired;
   logic        fin;
   logic        timed_out;
   logic [7:0]  fin_data;

`ifdef GM64_MEMTEST_EN
   logic             test_mode;   // the access in flight belongs to the self-test
   logic [OFF_W-1:0] test_off;
   logic [7:0]       test_rd;
   logic             done_q;
   logic             fail_q;
   assign o_testDone = done_q;
   assign o_testFail = fail_q;
`else
   assign o_testDone = 1'b1;
   assign o_testFail = 1'b0;
`endif

   assign tmo_active = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);

   // Counter is held cleared whenever no access is in flight, so every
   // access starts counting from zero.
   bridge_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clkSys  (clkSys),
      .rst     (rst),
      .clr     (!tmo_active),
      .en      (tmo_active),
      .expired (expired)
   );

   // End of the access in flight. A real completion in WAIT_DONE wins over
   // a timeout in the same cycle; a timed-out read returns 8'hFF.
   always_comb begin
      fin       = 1'b0;
      timed_out = 1'b0;
      fin_data  = i_dataRead;
      case (state)
         ISSUE, WAIT_BUSY: begin
            if (expired) begin
               fin       = 1'b1;
               timed_out = 1'b1;
               fin_data  = 8'hFF;
            end
         end
         WAIT_DONE: begin
            if (!i_busy && (we_q || i_dataReady)) begin
               fin = 1'b1;
            end else if (expired) begin
               fin       = 1'b1;
               timed_out = 1'b1;
               fin_data  = 8'hFF;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clkSys or negedge rst) begin
      if (!rst) begin
         state         <= RST_STATE;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wd_q          <= '0;
         o_cs          <= 1'b1;
         o_write       <= 1'b0;
         o_address     <= '0;
         o_dataToWrite <= '0;
         o_cpuData     <= '0;
         o_rdy         <= 1'b0;
         o_error       <= 1'b0;
`ifdef GM64_MEMTEST_EN
         test_mode     <= 1'b1;
         test_off      <= '0;
         test_rd       <= '0;
         done_q        <= 1'b0;
         fail_q        <= 1'b0;
`endif
      end else begin
         // o_cs is only pulled low by the ISSUE branch below, so it can
         // never stay low for two cycles.
         o_cs <= 1'b1;
         if (fin && timed_out)
            o_error <= 1'b1;

         case (state)
            IDLE: begin
               o_rdy <= !i_cpuStrobe;
               if (i_cpuStrobe) begin
                  addr_q <= i_cpuAddr;
                  we_q   <= i_cpuWE;
                  wd_q   <= i_cpuData;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (!fin && !i_busy) begin
                  o_cs          <= 1'b0;
                  o_address     <= mem_addr(BASE_ADDR, addr_q);
                  o_write       <= we_q;
                  o_dataToWrite <= wd_q;
                  state         <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!fin && i_busy)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: ;
`ifdef GM64_MEMTEST_EN
            TEST_WR: begin
               addr_q <= 16'(test_off);
               we_q   <= 1'b1;
               wd_q   <= TEST_PATTERN;
               state  <= ISSUE;
            end
            TEST_RD: begin
               we_q  <= 1'b0;
               state <= ISSUE;
            end
            TEST_CHK: begin
               // A mismatch parks the FSM here for good: o_rdy stays low.
               if (test_rd != TEST_PATTERN) begin
                  fail_q <= 1'b1;
                  done_q <= 1'b1;
               end else if (test_off == OFF_W'(TEST_LEN - 1)) begin
                  done_q    <= 1'b1;
                  test_mode <= 1'b0;
                  state     <= IDLE;
               end else begin
                  test_off <= test_off + 1'b1;
                  state    <= TEST_WR;
               end
            end
`endif
            default: state <= IDLE;
         endcase

         // Completion overrides any state update made above.
         if (fin) begin
`ifdef GM64_MEMTEST_EN
            if (test_mode) begin
               if (!we_q)
                  test_rd <= fin_data;
               state <= we_q ? TEST_RD : TEST_CHK;
            end else
`endif
            begin
               if (!we_q)
                  o_cpuData <= fin_data;
               o_rdy <= 1'b1;
               state <= IDLE;
            end
         end
      end
   end

endmodule
